uart_tx_word_fifo: RTL and testbench

Parametrised transmit queue between the execute stage and the UART `sender`, generalising the single-word send buffer. It accepts whole words, or single bytes, from the pipeline into a FIFO of configurable depth. It serialises each entry into bytes in a configurable order and hands them to `sender` over its enable/ready handshake. It exposes `full`, `almost_full` and an occupancy `count`, so instruction fetch can stall before overflow; pushes that arrive while full are reported through a sticky `overflow` flag.

---
 rtl/uart_tx_word_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_word_fifo.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_word_fifo.sv
// Transmit queue feeding the UART sender: a circular buffer of word/byte entries
// and a serialiser that hands bytes to the sender over its enable/ready handshake.
module uart_tx_word_fifo #(
  parameter int unsigned DEPTH_LOG2   = 4,
  parameter int unsigned WORD_BYTES   = 4,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter int unsigned AFULL_MARGIN = 2
) (
  input  logic                    CLK,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    push_byte_mode,
  input  logic [8*WORD_BYTES-1:0] push_data,
  output logic                    full,
  output logic                    almost_full,
  output logic [DEPTH_LOG2:0]     count,
  output logic                    overflow,
  output logic                    busy,
  input  logic                    sender_ready,
  output logic                    sender_enable,
  output logic [7:0]              sender_data
);

  localparam int unsigned Depth    = 1 << DEPTH_LOG2;
  localparam int unsigned DataW    = 8 * WORD_BYTES;
  localparam int unsigned NleftW   = $clog2(WORD_BYTES + 1);
  localparam int unsigned AfullInt = (AFULL_MARGIN >= Depth) ? 0 : Depth - AFULL_MARGIN;
  localparam logic [DEPTH_LOG2:0] DepthCnt = (DEPTH_LOG2 + 1)'(Depth);
  localparam logic [DEPTH_LOG2:0] AfullLvl = (DEPTH_LOG2 + 1)'(AfullInt);

  typedef enum logic [1:0] {StIdle, StSend, StGuard} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, rd_ptr_q;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic                    overflow_q;
  logic [DataW-1:0]        sh_q, sh_d;
  logic                    mode_q, mode_d;
  logic [NleftW-1:0]       nleft_q, nleft_d;
  logic                    en_q, en_d;
  logic [7:0]              data_q, data_d;
  logic [7:0]              cur_byte;
  logic [DataW:0]          mem [Depth];
  logic [DataW:0]          head;
  logic                    push_ok;
  logic                    pop;

  assign full        = (count_q == DepthCnt);
  assign almost_full = (count_q >= AfullLvl);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != StIdle) || (count_q != '0);
  assign sender_enable = en_q;
  assign sender_data   = data_q;

  // A push is judged against the registered count, so a same-cycle pop never frees a slot.
  assign push_ok = push && !full;
  assign pop     = (state_q == StIdle) && (count_q != '0);
  assign head    = mem[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_q] <= {push_byte_mode, push_data};
    end
  end

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push_ok && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Byte-mode entries always send the low byte, whatever the word order.
  always_comb begin
    if (mode_q || !MSB_FIRST) begin
      cur_byte = sh_q[7:0];
    end else begin
      cur_byte = sh_q[DataW-1 -: 8];
    end
  end

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    mode_d  = mode_q;
    nleft_d = nleft_q;
    en_d    = 1'b0;
    data_d  = data_q;
    case (state_q)
      StIdle: begin
        if (pop) begin
          sh_d    = head[DataW-1:0];
          mode_d  = head[DataW];
          nleft_d = head[DataW] ? NleftW'(1) : NleftW'(WORD_BYTES);
          state_d = StSend;
        end
      end
      StSend: begin
        if (sender_ready) begin
          en_d    = 1'b1;
          data_d  = cur_byte;
          sh_d    = MSB_FIRST ? (sh_q << 8) : (sh_q >> 8);
          nleft_d = nleft_q - 1'b1;
          state_d = StGuard;
        end
      end
      StGuard: begin
        // Gives the sender a cycle to drop ready before the next byte is offered.
        state_d = (nleft_q == '0) ? StIdle : StSend;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      sh_q       <= '0;
      mode_q     <= 1'b0;
      nleft_q    <= '0;
      en_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      sh_q     <= sh_d;
      mode_q   <= mode_d;
      nleft_q  <= nleft_d;
      en_q     <= en_d;
      data_q   <= data_d;
      if (push_ok) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      if (push && !push_ok) begin
        overflow_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_word_fifo.sv
// Bench for uart_tx_word_fifo: two instances (MSB-first and LSB-first) share stimulus and
// are checked every cycle against a queue-based model, plus literal scenario checks.
module tb_uart_tx_word_fifo;

  logic        CLK = 1'b0;
  logic        reset, push, push_byte_mode, sender_ready;
  logic [31:0] push_data;

  logic       full0, af0, ovf0, busy0, en0;
  logic [4:0] count0;
  logic [7:0] data0;
  logic       full1, af1, ovf1, busy1, en1;
  logic [4:0] count1;
  logic [7:0] data1;

  always #5 CLK = ~CLK;

  uart_tx_word_fifo u_dut0 (
    .CLK(CLK), .reset(reset), .push(push), .push_byte_mode(push_byte_mode),
    .push_data(push_data), .full(full0), .almost_full(af0), .count(count0),
    .overflow(ovf0), .busy(busy0), .sender_ready(sender_ready),
    .sender_enable(en0), .sender_data(data0)
  );

  uart_tx_word_fifo #(.MSB_FIRST(1'b0)) u_dut1 (
    .CLK(CLK), .reset(reset), .push(push), .push_byte_mode(push_byte_mode),
    .push_data(push_data), .full(full1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .busy(busy1), .sender_ready(sender_ready),
    .sender_enable(en1), .sender_data(data1)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: pending entries, bytes left of the word being sent, and a post-byte gap flag.
  typedef struct {bit mode; logic [31:0] data;} ent_t;
  ent_t       mq[$];
  logic [7:0] cur0[$], cur1[$];
  bit         m_loaded, m_gap, m_ovf, m_en;
  logic [7:0] m_d0, m_d1;
  int         cyc = 0;
  logic [7:0] log0[$], log1[$];
  int         first_en_cyc = -1;

  task automatic model_step();
    bit do_pop, acc;
    ent_t e;
    if (reset) begin
      mq.delete(); cur0.delete(); cur1.delete();
      m_loaded = 0; m_gap = 0; m_ovf = 0; m_en = 0; m_d0 = 0; m_d1 = 0;
      return;
    end
    do_pop = !m_loaded && mq.size() != 0;
    acc    = push && mq.size() < 16;
    m_en   = 0;
    if (push && !acc) m_ovf = 1;
    if (do_pop) begin
      e = mq.pop_front();
      if (e.mode) begin
        cur0.push_back(e.data[7:0]);
        cur1.push_back(e.data[7:0]);
      end else begin
        for (int b = 0; b < 4; b++) begin
          cur0.push_back(e.data[31-8*b -: 8]);
          cur1.push_back(e.data[8*b +: 8]);
        end
      end
      m_loaded = 1;
      m_gap = 0;
    end else if (m_loaded && m_gap) begin
      m_gap = 0;
      if (cur0.size() == 0) m_loaded = 0;
    end else if (m_loaded && sender_ready) begin
      m_en = 1;
      m_d0 = cur0.pop_front();
      m_d1 = cur1.pop_front();
      m_gap = 1;
    end
    if (acc) begin
      e.mode = push_byte_mode;
      e.data = push_data;
      mq.push_back(e);
    end
  endtask

  task automatic compare_outputs();
    int n;
    bit m_busy;
    n = mq.size();
    m_busy = m_loaded || (n != 0);
    chk("count0", count0, n);
    chk("count1", count1, n);
    chk("full0", full0, n == 16);
    chk("full1", full1, n == 16);
    chk("afull0", af0, n >= 14);
    chk("afull1", af1, n >= 14);
    chk("ovf0", ovf0, m_ovf);
    chk("ovf1", ovf1, m_ovf);
    chk("busy0", busy0, m_busy);
    chk("busy1", busy1, m_busy);
    chk("en0", en0, m_en);
    chk("en1", en1, m_en);
    chk("data0", data0, m_d0);
    chk("data1", data1, m_d1);
  endtask

  initial forever begin
    @(posedge CLK);
    cyc++;
    model_step();
    #1;
    compare_outputs();
    if (en0) begin
      log0.push_back(data0);
      if (first_en_cyc < 0) first_en_cyc = cyc;
    end
    if (en1) log1.push_back(data1);
  end

  task automatic do_push(input logic [31:0] d, input bit mode);
    push = 1;
    push_data = d;
    push_byte_mode = mode;
    @(negedge CLK);
    push = 0;
    push_byte_mode = 0;
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget && log0.size() < n; i++) @(negedge CLK);
    chk(name, log0.size() >= n, 1);
  endtask

  task automatic check_words(input string name, input logic [31:0] words[$]);
    chk({name, "_len0"}, log0.size(), 4 * words.size());
    chk({name, "_len1"}, log1.size(), 4 * words.size());
    if (log0.size() == 4 * words.size() && log1.size() == 4 * words.size()) begin
      for (int i = 0; i < words.size(); i++) begin
        for (int b = 0; b < 4; b++) begin
          chk({name, "_msb"}, log0[4*i+b], words[i][31-8*b -: 8]);
          chk({name, "_lsb"}, log1[4*i+b], words[i][8*b +: 8]);
        end
      end
    end
  endtask

  logic [31:0] words[$];
  int pcyc;
  int af_first;
  int n;
  bit did16, did5, c16, c5;

  initial begin
    reset = 1; push = 0; push_byte_mode = 0; push_data = 0; sender_ready = 1;
    repeat (2) @(negedge CLK);
    chk("rst_count", count0, 0);
    chk("rst_full", full0, 0);
    chk("rst_afull", af0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_en", en0, 0);
    chk("rst_data", data0, 8'h00);
    reset = 0;
    @(negedge CLK);

    // Single word, ready held high.
    pcyc = cyc + 1;
    do_push(32'h12345678, 0);
    chk("t1_count1", count0, 1);
    wait_log(4, 40, "t1_wait");
    chk("t1_latency", first_en_cyc - pcyc, 2);
    chk("t1_busy_last", busy0, 1);
    @(negedge CLK);
    chk("t1_busy_done", busy0, 0);
    chk("t1_b0", log0[0], 8'h12);
    chk("t1_b3", log0[3], 8'h78);
    chk("t1_lsb_b0", log1[0], 8'h78);
    chk("t1_lsb_b3", log1[3], 8'h12);
    words = '{32'h12345678};
    check_words("t1", words);

    // Byte mode sends only the low byte for either order.
    log0.delete(); log1.delete();
    do_push(32'hAABBCC41, 1);
    repeat (20) @(negedge CLK);
    chk("t2_len0", log0.size(), 1);
    chk("t2_len1", log1.size(), 1);
    if (log0.size() == 1 && log1.size() == 1) begin
      chk("t2_b0", log0[0], 8'h41);
      chk("t2_b1", log1[0], 8'h41);
    end

    // Fill with ready low; one word sits in the serialiser, so the 18th push overflows.
    log0.delete(); log1.delete(); words.delete();
    sender_ready = 0;
    af_first = -1;
    for (int k = 0; k < 18; k++) begin
      logic [31:0] w;
      w = $urandom;
      if (k < 17) words.push_back(w);
      do_push(w, 0);
      if (af0 && af_first < 0) af_first = count0;
      if (k == 16) chk("t3_no_ovf_yet", ovf0, 0);
    end
    chk("t3_af_first", af_first, 14);
    chk("t3_full", full0, 1);
    chk("t3_count", count0, 16);
    chk("t3_ovf", ovf0, 1);

    // Drain, pushing alongside the pop at count 16 (rejected) and at count 5 (accepted).
    sender_ready = 1;
    did16 = 0; did5 = 0;
    for (int i = 0; i < 600 && !(did5 && !busy0); i++) begin
      push = 0; c16 = 0; c5 = 0;
      if (!did16 && !m_loaded && mq.size() == 16) begin
        push = 1; push_data = 32'hDEADBEEF; c16 = 1; did16 = 1;
      end else if (did16 && !did5 && !m_loaded && mq.size() == 5) begin
        push = 1; push_data = $urandom; words.push_back(push_data); c5 = 1; did5 = 1;
      end
      @(negedge CLK);
      if (c16) begin
        chk("t4_full_pop_count", count0, 15);
        chk("t4_full_pop_ovf", ovf0, 1);
      end
      if (c5) chk("t4_mid_pop_count", count0, 5);
    end
    push = 0;
    chk("t4_done", did5 && !busy0, 1);
    check_words("t3", words);

    // Random ready, 40 sequential words to exercise pointer wrap.
    reset = 1;
    @(negedge CLK);
    reset = 0;
    chk("t5_ovf_clr", ovf0, 0);
    log0.delete(); log1.delete(); words.delete();
    n = 0;
    for (int i = 0; i < 3000 && n < 40; i++) begin
      sender_ready = 1'($urandom_range(0, 1));
      if (!full0 && $urandom_range(0, 3) != 0) begin
        push = 1; push_data = n; words.push_back(n); n++;
      end else begin
        push = 0;
      end
      @(negedge CLK);
    end
    push = 0;
    chk("t5_pushed", n, 40);
    for (int i = 0; i < 3000 && busy0; i++) begin
      sender_ready = 1'($urandom_range(0, 1));
      @(negedge CLK);
    end
    chk("t5_idle", busy0, 0);
    check_words("t5", words);

    // Reset in the middle of a word.
    sender_ready = 1;
    log0.delete(); log1.delete();
    do_push(32'h11223344, 0);
    do_push(32'h55667788, 0);
    do_push(32'h99AABBCC, 0);
    wait_log(2, 40, "t6_wait");
    reset = 1;
    @(negedge CLK);
    reset = 0;
    chk("t6_count", count0, 0);
    chk("t6_ovf", ovf0, 0);
    chk("t6_busy", busy0, 0);
    repeat (10) @(negedge CLK);
    chk("t6_no_more", log0.size(), 2);
    log0.delete(); log1.delete();
    do_push(32'hCAFEF00D, 0);
    wait_log(4, 40, "t6_wait2");
    @(negedge CLK);
    words = '{32'hCAFEF00D};
    check_words("t6", words);
    chk("t6_first", log0[0], 8'hCA);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

endmodule
